gpu_frame_sequencer: RTL and testbench
======================================

GPU_FRAME_SEQUENCER -- requirements
Module: gpu_frame_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 1200, framebuffer words (40x30 characters).
REQ-002 SHALL have parameter ADDR_W, default 11, framebuffer address width.
REQ-003 SHALL have parameter DATA_W, default 64, framebuffer word width.
REQ-004 SHALL have port clock  input  1  sole clock (processor clock domain).
REQ-005 SHALL have port resetN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port vblank  input  1  high while in vertical blank, synchronous to clock.
REQ-007 SHALL have port startCopy  input  1  one-cycle pulse; copies external framebuffer into internal framebuffer.
REQ-008 SHALL have port startClear  input  1  one-cycle pulse; zeroes both framebuffers.
REQ-009 SHALL have port procReq  input  1  processor requests the external framebuffer port.
REQ-010 SHALL have port procWrite  input  1  processor write qualifier.
REQ-011 SHALL have port procAddr  input  ADDR_W  processor word address.
REQ-012 SHALL have port procWData  input  DATA_W  processor write data.
REQ-013 SHALL have port procGrant  output  1  processor owns the external port this cycle.
REQ-014 SHALL have port extAddr / extWData / extWrite  output  ADDR_W / DATA_W / 1  external framebuffer port.
REQ-015 SHALL have port extRData  input  DATA_W  external framebuffer read data, one-cycle latency.
REQ-016 SHALL have port intAddr / intWData / intWrite  output  ADDR_W / DATA_W / 1  internal framebuffer write port.
REQ-017 SHALL have port busy  output  1  a copy or clear is pending or running.
REQ-018 SHALL have port done  output  1  one-cycle pulse when an operation completes.
REQ-019 SHALL have port frameCount  output  16  count of completed operations (see Configuration).

Function
REQ-020 SHALL implement states IDLE, WAIT_VB, CLEAR, COPY, DRAIN, DONE.
REQ-021 IDLE: startClear or startCopy -> WAIT_VB; latches a pending flag per request.
REQ-022 Both pending: clear takes priority; the pending copy flag is discarded when the clear completes.
REQ-023 WAIT_VB: on vblank=1 -> CLEAR if clear pending, else COPY; counter set to 0.
REQ-024 CLEAR: each cycle with vblank=1 drives extWrite=intWrite=1, extAddr=intAddr=counter, data 0; DEPTH cycles total.
REQ-025 COPY: each cycle with vblank=1 drives extAddr=counter (read); intWrite=1 with intAddr=counter-1, intWData=extRData from cycle 1 onward.
REQ-026 COPY -> DRAIN after reading address DEPTH-1; DRAIN writes the final word; copy takes DEPTH+1 active cycles.
REQ-027 vblank=0 during CLEAR/COPY/DRAIN: all writes deasserted, counter and read pipeline held; resume when vblank returns, no word skipped or duplicated.
REQ-028 DONE: done=1 for one cycle, pending flags cleared, -> IDLE.
REQ-029 procGrant = procReq in IDLE and WAIT_VB, else 0; the processor holds procReq until granted.
REQ-030 When granted: extAddr=procAddr, extWData=procWData, extWrite=procWrite; else ext port driven by sequencer (idle: address 0, writes 0).
REQ-031 Start pulses arriving in CLEAR/COPY/DRAIN SHALL be latched and served after DONE via WAIT_VB.
REQ-032 busy = (state != IDLE).
REQ-033 Counter SHALL compare against DEPTH-1 only; it never wraps past DEPTH-1.

Reset
REQ-034 resetN=0 SHALL asynchronously force state IDLE, counter 0, pending flags 0, frameCount 0.
REQ-035 During reset all outputs SHALL be 0; an operation cut by reset is abandoned, not resumed.

Configuration
REQ-036 GPU_SEQ_STATS_EN defined: frameCount increments at DONE, 16-bit wrap 0xFFFF -> 0.
REQ-037 GPU_SEQ_STATS_EN undefined: frameCount tied to 0; no counter register synthesized.

Structure
REQ-038 Package gpu_seq_pkg SHALL hold the state typedef and the defaults for DEPTH, ADDR_W, DATA_W.
REQ-039 One sub-module gpu_seq_counter (hold, clear, terminal flag at DEPTH-1) SHALL be instantiated once.

Verification
REQ-040 startCopy, vblank held 1, ext[n]=n -> int[n]=n for n=0..1199, done 1201 cycles after COPY entry.
REQ-041 startClear and startCopy same cycle -> both framebuffers all 0 after 1200 write cycles, one done pulse, no copy.
REQ-042 vblank drops for 50 cycles at counter=600 during COPY -> no writes in gap, all 1200 words correct.
REQ-043 procReq during COPY -> procGrant=0 until DONE, granted the cycle after in IDLE.
REQ-044 resetN low at counter=300 -> outputs 0 immediately, state IDLE, busy=0.
REQ-045 GPU_SEQ_STATS_EN defined, 3 copies -> frameCount=3; undefined -> frameCount=0.

Source files
------------

// File: rtl/gpu_seq_pkg.sv
// rtl/gpu_seq_pkg.sv - state type and default framebuffer geometry for the frame sequencer
package gpu_seq_pkg;

  localparam int DEPTH_DEFAULT  = 1200;
  localparam int ADDR_W_DEFAULT = 11;
  localparam int DATA_W_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VB,
    CLEAR,
    COPY,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/gpu_seq_counter.sv
// rtl/gpu_seq_counter.sv - framebuffer word counter with hold, clear and terminal flag
// Saturates at DEPTH-1 so a stray enable can never address past the framebuffer.
module gpu_seq_counter
  import gpu_seq_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST);

endmodule

// File: rtl/gpu_frame_sequencer.sv
// rtl/gpu_frame_sequencer.sv - vblank-gated copy/clear sequencer between external and internal framebuffers
// Optional frame statistics counter enabled by defining GPU_SEQ_STATS_EN.
module gpu_frame_sequencer
  import gpu_seq_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              vblank,
  input  logic              startCopy,
  input  logic              startClear,
  input  logic              procReq,
  input  logic              procWrite,
  input  logic [ADDR_W-1:0] procAddr,
  input  logic [DATA_W-1:0] procWData,
  output logic              procGrant,
  output logic [ADDR_W-1:0] extAddr,
  output logic [DATA_W-1:0] extWData,
  output logic              extWrite,
  input  logic [DATA_W-1:0] extRData,
  output logic [ADDR_W-1:0] intAddr,
  output logic [DATA_W-1:0] intWData,
  output logic              intWrite,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frameCount
);

  seq_state_e        state_q;
  logic              pend_clear_q;
  logic              pend_copy_q;
  logic              queue_clear_q;
  logic              queue_copy_q;
  logic [ADDR_W-1:0] count;
  logic              count_last;
  logic              running;
  logic              cnt_en;
  logic [ADDR_W-1:0] seq_addr;

  assign running = (state_q == CLEAR) || (state_q == COPY) || (state_q == DRAIN);
  assign cnt_en  = vblank && ((state_q == CLEAR) || (state_q == COPY));

  gpu_seq_counter #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clock   (clock),
    .resetN  (resetN),
    .clr_i   (!running),
    .en_i    (cnt_en),
    .count_o (count),
    .last_o  (count_last)
  );

  // pend_* drive the operation in flight; queue_* hold requests that arrive while it runs.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      pend_clear_q  <= 1'b0;
      pend_copy_q   <= 1'b0;
      queue_clear_q <= 1'b0;
      queue_copy_q  <= 1'b0;
    end else begin
      if (running || (state_q == DONE)) begin
        queue_clear_q <= queue_clear_q | startClear;
        queue_copy_q  <= queue_copy_q | startCopy;
      end
      case (state_q)
        IDLE: begin
          if (startClear || startCopy || queue_clear_q || queue_copy_q) begin
            state_q       <= WAIT_VB;
            pend_clear_q  <= startClear | queue_clear_q;
            pend_copy_q   <= startCopy | queue_copy_q;
            queue_clear_q <= 1'b0;
            queue_copy_q  <= 1'b0;
          end
        end
        WAIT_VB: begin
          pend_clear_q <= pend_clear_q | startClear;
          pend_copy_q  <= pend_copy_q | startCopy;
          if (vblank) begin
            if (pend_clear_q || startClear) begin
              state_q <= CLEAR;
            end else if (pend_copy_q || startCopy) begin
              state_q <= COPY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        CLEAR: begin
          if (vblank && count_last) state_q <= DONE;
        end
        COPY: begin
          if (vblank && count_last) state_q <= DRAIN;
        end
        DRAIN: begin
          if (vblank) state_q <= DONE;
        end
        DONE: begin
          pend_clear_q <= 1'b0;
          pend_copy_q  <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A copy stall re-reads the previous address so extRData still holds the word awaiting its write.
  always_comb begin
    seq_addr = '0;
    case (state_q)
      CLEAR:   seq_addr = count;
      COPY:    seq_addr = (vblank || (count == '0)) ? count : count - ADDR_W'(1);
      DRAIN:   seq_addr = count;
      default: seq_addr = '0;
    endcase
  end

  assign procGrant = resetN && procReq && ((state_q == IDLE) || (state_q == WAIT_VB));
  assign extAddr   = procGrant ? procAddr : seq_addr;
  assign extWData  = procGrant ? procWData : '0;
  assign extWrite  = procGrant ? procWrite : (vblank && (state_q == CLEAR));

  assign intWrite = vblank && ((state_q == CLEAR) || (state_q == DRAIN) ||
                               ((state_q == COPY) && (count != '0)));
  assign intAddr  = (state_q == COPY) ? count - ADDR_W'(1) :
                    ((state_q == CLEAR) || (state_q == DRAIN)) ? count : '0;
  assign intWData = ((state_q == COPY) || (state_q == DRAIN)) ? extRData : '0;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

`ifdef GPU_SEQ_STATS_EN
  logic [15:0] frame_count_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      frame_count_q <= 16'd0;
    end else if (state_q == DONE) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frameCount = frame_count_q;
`else
  assign frameCount = 16'd0;
`endif

endmodule

// File: tb/tb_gpu_frame_sequencer.sv
// tb/tb_gpu_frame_sequencer.sv - self-checking bench for gpu_frame_sequencer
module tb_gpu_frame_sequencer;

  localparam int DEPTH = 1200;
  localparam int AW    = 11;
  localparam int DW    = 64;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          vblank = 1'b0;
  logic          startCopy = 1'b0;
  logic          startClear = 1'b0;
  logic          procReq = 1'b0;
  logic          procWrite = 1'b0;
  logic [AW-1:0] procAddr = '0;
  logic [DW-1:0] procWData = '0;
  logic          procGrant;
  logic [AW-1:0] extAddr;
  logic [DW-1:0] extWData;
  logic          extWrite;
  logic [DW-1:0] extRData = '0;
  logic [AW-1:0] intAddr;
  logic [DW-1:0] intWData;
  logic          intWrite;
  logic          busy;
  logic          done;
  logic [15:0]   frameCount;

  gpu_frame_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .resetN(resetN), .vblank(vblank),
    .startCopy(startCopy), .startClear(startClear),
    .procReq(procReq), .procWrite(procWrite), .procAddr(procAddr), .procWData(procWData),
    .procGrant(procGrant),
    .extAddr(extAddr), .extWData(extWData), .extWrite(extWrite), .extRData(extRData),
    .intAddr(intAddr), .intWData(intWData), .intWrite(intWrite),
    .busy(busy), .done(done), .frameCount(frameCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_grant;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          exp_write;
  } vec_t;

  wr_t           exp_int_q[$];
  wr_t           exp_ext_q[$];
  logic [DW-1:0] ext_mem [0:2047];
  logic [DW-1:0] int_mem [0:2047];
  logic          fill_req = 1'b0;
  int            fill_sel = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            done_cnt = 0;

  function automatic logic [DW-1:0] pat(input int sel, input int n);
    if (sel == 0) return 64'(n);
    return 64'(n) * 64'h9E37_79B9_7F4A_7C15 + 64'(sel);
  endfunction

  always @(posedge clock) begin
    if (fill_req) begin
      for (int n = 0; n < 2048; n++) begin
        ext_mem[AW'(n)] <= pat(fill_sel, n);
        int_mem[AW'(n)] <= 64'hDEAD_BEEF_0000_0000 | 64'(n);
      end
    end else begin
      if (extWrite) ext_mem[extAddr] <= extWData;
      if (intWrite) int_mem[intAddr] <= intWData;
    end
    extRData <= ext_mem[extAddr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    #2;
    if (resetN) begin
      if (done) done_cnt++;
      if (intWrite) begin
        if (exp_int_q.size() == 0) begin
          check("int_unexpected_write", 64'(intAddr), 64'hFFFF);
        end else begin
          wr_t e;
          e = exp_int_q.pop_front();
          check("int_addr", 64'(intAddr), 64'(e.addr));
          check("int_data", intWData, e.data);
        end
      end
      if (extWrite && !procGrant) begin
        if (exp_ext_q.size() == 0) begin
          check("ext_unexpected_write", 64'(extAddr), 64'hFFFF);
        end else begin
          wr_t e;
          e = exp_ext_q.pop_front();
          check("ext_addr", 64'(extAddr), 64'(e.addr));
          check("ext_data", extWData, e.data);
        end
      end
      if (busy && !vblank)
        check("no_write_without_vblank", 64'({intWrite, extWrite && !procGrant}), 64'd0);
    end
  end

  task automatic fill(input int sel);
    @(negedge clock);
    fill_sel = sel;
    fill_req = 1'b1;
    @(negedge clock);
    fill_req = 1'b0;
  endtask

  task automatic push_copy(input int sel);
    for (int n = 0; n < DEPTH; n++) exp_int_q.push_back('{addr: AW'(n), data: pat(sel, n)});
  endtask

  task automatic push_clear();
    for (int n = 0; n < DEPTH; n++) begin
      exp_int_q.push_back('{addr: AW'(n), data: 64'd0});
      exp_ext_q.push_back('{addr: AW'(n), data: 64'd0});
    end
  endtask

  task automatic pulse_start(input logic c, input logic cl);
    @(negedge clock);
    startCopy  = c;
    startClear = cl;
    @(negedge clock);
    startCopy  = 1'b0;
    startClear = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    while (cyc < budget && !seen) begin
      @(negedge clock);
      cyc++;
      #1;
      if (done) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic mem_check(input string name, input int sel, input logic zero);
    int bad;
    bad = 0;
    for (int n = 0; n < DEPTH; n++) begin
      if (int_mem[AW'(n)] !== (zero ? 64'd0 : pat(sel, n))) bad++;
      if (zero && ext_mem[AW'(n)] !== 64'd0) bad++;
    end
    check(name, 64'(bad), 64'd0);
  endtask

  vec_t vecs[4];
  int   cyc;
  int   d0;
  int   grant_bad;
  logic found;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 11'h123, 64'hAAAA, 1'b0, 11'h000, 64'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 11'h123, 64'h5555, 1'b1, 11'h123, 64'h5555, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 11'h7FF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 11'h7FF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 11'h055, 64'h1, 1'b0, 11'h000, 64'h0, 1'b0};

    // Reset: outputs forced low even with a processor request and vblank present.
    procReq = 1'b1;
    vblank  = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(procGrant), 64'd0);
    check("rst_extaddr", 64'(extAddr), 64'd0);
    check("rst_writes", 64'({extWrite, intWrite, done}), 64'd0);
    check("rst_framecount", 64'(frameCount), 64'd0);
    @(negedge clock);
    procReq = 1'b0;
    resetN  = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      procReq   = vecs[i].req;
      procWrite = vecs[i].wr;
      procAddr  = vecs[i].addr;
      procWData = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_grant", i), 64'(procGrant), 64'(vecs[i].exp_grant));
      check($sformatf("vec%0d_addr", i), 64'(extAddr), 64'(vecs[i].exp_addr));
      check($sformatf("vec%0d_wdata", i), extWData, vecs[i].exp_wdata);
      check($sformatf("vec%0d_write", i), 64'(extWrite), 64'(vecs[i].exp_write));
    end
    @(negedge clock);
    procReq = 1'b0;
    procWrite = 1'b0;

    // Plain copy with ext[n]=n and vblank held high.
    fill(0);
    push_copy(0);
    pulse_start(1'b1, 1'b0);
    wait_done("copy_done", 1500, cyc);
    check("copy_latency", 64'(cyc), 64'd1202);
    @(negedge clock);
    #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_copy", 64'(busy), 64'd0);
    mem_check("copy_mem", 0, 1'b0);

    // Simultaneous clear and copy: clear wins and the copy is dropped.
    fill(1);
    push_clear();
    d0 = done_cnt;
    pulse_start(1'b1, 1'b1);
    wait_done("clear_done", 1500, cyc);
    check("clear_latency", 64'(cyc), 64'd1201);
    repeat (20) @(negedge clock);
    #1;
    check("clear_no_copy_busy", 64'(busy), 64'd0);
    check("clear_done_pulses", 64'(done_cnt - d0), 64'd1);
    mem_check("clear_mem", 0, 1'b1);

    // Copy waiting for vblank, then a 50-cycle vblank gap at counter 600.
    fill(2);
    push_copy(2);
    @(negedge clock);
    vblank = 1'b0;
    pulse_start(1'b1, 1'b0);
    repeat (10) @(negedge clock);
    #1;
    check("waitvb_busy", 64'(busy), 64'd1);
    @(negedge clock);
    procReq  = 1'b1;
    procAddr = 11'h2AA;
    #1;
    check("waitvb_grant", 64'(procGrant), 64'd1);
    check("waitvb_addr", 64'(extAddr), 64'h2AA);
    @(negedge clock);
    procReq = 1'b0;
    vblank  = 1'b1;
    found   = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clock);
      #1;
      if (busy && extAddr == 11'd600) found = 1'b1;
    end
    check("gap_reached_600", 64'(found), 64'd1);
    vblank = 1'b0;
    repeat (50) @(negedge clock);
    vblank = 1'b1;
    wait_done("gap_done", 1500, cyc);
    @(negedge clock);
    mem_check("gap_mem", 2, 1'b0);

    // Processor locked out during copy; clear pulse mid-copy runs afterwards.
    fill(3);
    push_copy(3);
    push_clear();
    d0 = done_cnt;
    pulse_start(1'b1, 1'b0);
    repeat (100) @(negedge clock);
    procReq = 1'b1;
    pulse_start(1'b0, 1'b1);
    grant_bad = 0;
    found = 1'b0;
    for (int i = 0; i < 1500 && !found; i++) begin
      @(negedge clock);
      #1;
      if (done) found = 1'b1;
      else if (procGrant) grant_bad++;
    end
    check("lockout_done", 64'(found), 64'd1);
    check("lockout_grants", 64'(grant_bad), 64'd0);
    check("grant_at_done", 64'(procGrant), 64'd0);
    @(negedge clock);
    #1;
    check("grant_in_idle", 64'(procGrant), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    @(negedge clock);
    procReq = 1'b0;
    #1;
    check("queued_clear_busy", 64'(busy), 64'd1);
    wait_done("queued_clear_done", 1500, cyc);
    repeat (5) @(negedge clock);
    check("queued_done_pulses", 64'(done_cnt - d0), 64'd2);
    mem_check("queued_clear_mem", 0, 1'b1);

    // Reset in the middle of a copy abandons it.
    fill(4);
    push_copy(4);
    pulse_start(1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clock);
      #1;
      if (busy && extAddr == 11'd300) found = 1'b1;
    end
    check("reset_reached_300", 64'(found), 64'd1);
    procReq = 1'b1;
    resetN  = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_outs", 64'({procGrant, extWrite, intWrite, done}), 64'd0);
    check("midrst_addr", 64'({extAddr, intAddr}), 64'd0);
    check("midrst_data", intWData | extWData, 64'd0);
    exp_int_q.delete();
    exp_ext_q.delete();
    @(negedge clock);
    resetN  = 1'b1;
    procReq = 1'b0;
    repeat (20) @(negedge clock);
    #1;
    check("after_rst_idle", 64'(busy), 64'd0);
    check("after_rst_framecount", 64'(frameCount), 64'd0);

    // Three copies for the statistics counter.
    for (int k = 0; k < 3; k++) begin
      fill(5 + k);
      push_copy(5 + k);
      pulse_start(1'b1, 1'b0);
      wait_done($sformatf("stats_copy%0d_done", k), 1500, cyc);
      @(negedge clock);
    end
    #1;
`ifdef GPU_SEQ_STATS_EN
    check("framecount", 64'(frameCount), 64'd3);
`else
    check("framecount", 64'(frameCount), 64'd0);
`endif
    mem_check("stats_mem", 7, 1'b0);
    repeat (3) @(negedge clock);
    check("sb_int_drained", 64'(exp_int_q.size()), 64'd0);
    check("sb_ext_drained", 64'(exp_ext_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
